// File: rtl/cond_seq_pkg.sv
// Shared condition codes, sequencer states and the ARM condition evaluator.
// Used by cond_checker and cond_flag_sequencer.
package cond_seq_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_EXEC,
    S_LOAD,
    S_SETTLE
  } state_e;

  function automatic logic cond_eval(
    input logic [3:0] cond,
    input logic       n,
    input logic       z,
    input logic       c,
    input logic       v
  );
    logic r;
    r = 1'b0;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = c;
      COND_CC: r = !c;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = c && !z;
      COND_LS: r = !c || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_flag_sequencer_checker.sv
// Combinational ARM condition check against N/Z/C/V.
// Shared with the branch unit.
module cond_checker
  import cond_seq_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       c_i,
  input  logic       v_i,
  output logic       pass_o
);

  assign pass_o = cond_eval(cond_i, n_i, z_i, c_i, v_i);

endmodule

// File: rtl/cond_flag_sequencer.sv
// Conditional-execution sequencer between issue logic and the ALU/flag pair.
// Define COND_STATS_EN to add exec_count/skip_count statistics outputs.
module cond_flag_sequencer
  import cond_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ALU_TIMEOUT   = 15
`ifdef COND_STATS_EN
  ,
  parameter int CNT_W         = 16
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] cond,
  input  logic       s_bit,
  input  logic       n_flag,
  input  logic       z_flag,
  input  logic       c_flag,
  input  logic       v_flag,
  output logic       alu_start,
  input  logic       alu_done,
  output logic       frld,
  output logic       cond_pass,
  output logic       instr_done,
  output logic       skipped,
  output logic       timeout_err,
  input  logic       clr_err
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
`endif
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam int SW = (SETTLE_CYCLES > 0) ?
                      $clog2(SETTLE_CYCLES + 1) : 1;

  state_e        state_q, state_d;
  logic [3:0]    cond_q, cond_d;
  logic          sbit_q, sbit_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          ready_q, ready_d;
  logic          start_q, start_d;
  logic          frld_q, frld_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic          skip_q, skip_d;
  logic          terr_q, terr_d;
  logic          to_hit;
  logic          eval_pass;

  cond_checker u_chk (
    .cond_i (cond_q),
    .n_i    (n_flag),
    .z_i    (z_flag),
    .c_i    (c_flag),
    .v_i    (v_flag),
    .pass_o (eval_pass)
  );

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    sbit_d  = sbit_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    start_d = 1'b0;
    frld_d  = 1'b0;
    pass_d  = pass_q;
    done_d  = 1'b0;
    skip_d  = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          cond_d  = cond;
          sbit_d  = s_bit;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        pass_d = eval_pass;
        if (eval_pass) begin
          state_d = S_EXEC;
          start_d = 1'b1;
          tcnt_d  = TW'(1);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          skip_d  = 1'b1;
        end
      end
      S_EXEC: begin
        tcnt_d = tcnt_q + TW'(1);
        if (alu_done) begin
          if (sbit_q) begin
            state_d = S_LOAD;
            frld_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (tcnt_q == TW'(ALU_TIMEOUT)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          to_hit  = 1'b1;
        end
      end
      S_LOAD: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = S_SETTLE;
          scnt_d  = SW'(1);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (scnt_q == SW'(SETTLE_CYCLES)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // set beats clear so a fresh timeout is never lost
    terr_d = to_hit ? 1'b1 : (clr_err ? 1'b0 : terr_q);
    // completion cycle is not an accept cycle
    ready_d = (state_d == S_IDLE) && !done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cond_q  <= '0;
      sbit_q  <= 1'b0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      frld_q  <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      skip_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      sbit_q  <= sbit_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
      ready_q <= ready_d;
      start_q <= start_d;
      frld_q  <= frld_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      skip_q  <= skip_d;
      terr_q  <= terr_d;
    end
  end

  assign instr_ready = ready_q;
  assign alu_start   = start_q;
  assign frld        = frld_q;
  assign cond_pass   = pass_q;
  assign instr_done  = done_q;
  assign skipped     = skip_q;
  assign timeout_err = terr_q;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_q, skipc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q  <= '0;
      skipc_q <= '0;
    end else if (state_q == S_EVAL) begin
      if (eval_pass && !(&exec_q))
        exec_q <= exec_q + 1'b1;
      if (!eval_pass && !(&skipc_q))
        skipc_q <= skipc_q + 1'b1;
    end
  end

  assign exec_count = exec_q;
  assign skip_count = skipc_q;
`endif

endmodule
